// File: rtl/t07_tft_arbiter.sv
// Two-requester round-robin arbiter in front of the t07_spitft engine.
// Holds wi/address/data until ack, aborts hung transfers, then enforces an idle gap.
module t07_tft_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] data0,
  output logic        done0,
  output logic        err0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] data1,
  output logic        done1,
  output logic        err1,
  output logic        spi_wi,
  output logic [31:0] spi_address,
  output logic [31:0] spi_data,
  input  logic        spi_ack,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          wi_q, wi_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          busy_q, busy_d;
  logic          win_s;

  // Next-state, arbitration and output decode
  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    win_s   = 1'b0;

    // On a tie the requester that did not win last time takes the engine
    if (req0 && req1) begin
      win_s = ~last_q;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACTIVE;
          wi_d    = 1'b1;
          addr_d  = win_s ? addr1 : addr0;
          data_d  = win_s ? data1 : data0;
          grant_d = win_s ? 2'b10 : 2'b01;
          last_d  = win_s;
          tcnt_d  = {TW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        // The one-hot grant doubles as the done/err pulse vector for the owner
        if (spi_ack) begin
          state_d = GAP;
          wi_d    = 1'b0;
          grant_d = 2'b00;
          done_d  = grant_q;
          gcnt_d  = {GW{1'b0}};
        end else if (tcnt_q == T_LAST) begin
          state_d = GAP;
          wi_d    = 1'b0;
          grant_d = 2'b00;
          err_d   = grant_q;
          gcnt_d  = {GW{1'b0}};
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
        end
      end
      GAP: begin
        if (gcnt_q == G_LAST) begin
          state_d = IDLE;
        end else begin
          gcnt_d  = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wi_d    = 1'b0;
        grant_d = 2'b00;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wi_q    <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      tcnt_q  <= {TW{1'b0}};
      gcnt_q  <= {GW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      busy_q  <= busy_d;
    end
  end

  assign spi_wi      = wi_q;
  assign spi_address = addr_q;
  assign spi_data    = data_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign done0       = done_q[0];
  assign done1       = done_q[1];
  assign err0        = err_q[0];
  assign err1        = err_q[1];

endmodule
